// File: rtl/regfile_dump.sv
// Debug read-out engine: walks the register file two entries at a time and streams
// each value with its index. Optional checksum beat under `REGFILE_DUMP_CHECKSUM_EN`.
module regfile_dump #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned IDX_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] RS1,
  output logic [IDX_W-1:0] RS2,
  input  logic [XLEN-1:0]  ReadData1,
  input  logic [XLEN-1:0]  ReadData2,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [XLEN-1:0]  dump_data,
  output logic [IDX_W-1:0] dump_index,
  output logic             dump_last,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] LastPair = IDX_W'(NUM_REGS / 2 - 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StRead, StSend0, StSend1, StFin, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StRead, StSend0, StSend1, StDone} state_e;
`endif

  state_e           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0]  buf1_q, buf1_d;
  logic             valid_q, valid_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [XLEN-1:0]  acc_q, acc_d;
`endif

  logic hs;
  assign hs = valid_q & dump_ready;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    buf1_d  = buf1_q;
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    acc_d   = acc_q;
    if (hs && state_q != StFin) acc_d = acc_q ^ data_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          k_d     = '0;
          rs1_d   = '0;
          rs2_d   = IDX_W'(1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      StRead: begin
        // Entry 0 of the pair buffer lives directly in the output data register.
        data_d  = ReadData1;
        buf1_d  = ReadData2;
        index_d = rs1_q;
        last_d  = 1'b0;
        valid_d = 1'b1;
        state_d = StSend0;
      end
      StSend0: begin
        if (hs) begin
          data_d  = buf1_q;
          index_d = rs2_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          last_d  = 1'b0;
`else
          last_d  = (k_q == LastPair);
`endif
          state_d = StSend1;
        end
      end
      StSend1: begin
        if (hs) begin
          if (k_q != LastPair) begin
            k_d     = k_q + IDX_W'(1);
            rs1_d   = k_d << 1;
            rs2_d   = (k_d << 1) | IDX_W'(1);
            valid_d = 1'b0;
            state_d = StRead;
          end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            data_d  = acc_q ^ data_q;
            index_d = '0;
            last_d  = 1'b1;
            state_d = StFin;
`else
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
`endif
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      StFin: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
`endif
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      buf1_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      buf1_q  <= buf1_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign RS1        = rs1_q;
  assign RS2        = rs2_q;
  assign dump_valid = valid_q;
  assign dump_data  = data_q;
  assign dump_index = index_q;
  assign dump_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: register file model plus a beat-sequence
// reference built directly from the expected register contents.
module tb_regfile_dump;

  localparam int NR = 32;
  localparam int XL = 64;
  localparam int IW = 5;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int NBEATS = NR + 1;
`else
  localparam int NBEATS = NR;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [IW-1:0] RS1, RS2;
  logic [XL-1:0] ReadData1, ReadData2;
  logic          dump_valid, dump_ready;
  logic [XL-1:0] dump_data;
  logic [IW-1:0] dump_index;
  logic          dump_last, busy, done;

  logic [XL-1:0] regs  [NR];
  logic [XL-1:0] exp_v [NR];

  assign ReadData1 = regs[RS1];
  assign ReadData2 = regs[RS2];

  always #5 clk = ~clk;

  regfile_dump #(.XLEN(XL), .NUM_REGS(NR), .IDX_W(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .RS1        (RS1),
    .RS2        (RS2),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_index (dump_index),
    .dump_last  (dump_last),
    .busy       (busy),
    .done       (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [XL-1:0] got_data [$];
  logic [IW-1:0] got_idx  [$];
  logic          got_last [$];
  int            got_j    [$];
  int            done_cnt, done_j, first_valid_j;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rs1"},   64'(RS1), 64'd0);
    chk({tag, "_rs2"},   64'(RS2), 64'd0);
    chk({tag, "_valid"}, 64'(dump_valid), 64'd0);
    chk({tag, "_data"},  dump_data, 64'd0);
    chk({tag, "_index"}, 64'(dump_index), 64'd0);
    chk({tag, "_last"},  64'(dump_last), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
  endtask

  // mode: 0 plain, 1 start pulses while busy, 2 regfile writes mid-dump, 3 reset in pair 5
  task automatic run_dump(input int pct, input int mode);
    bit            prev_stall = 0;
    bit            wrote = 0;
    logic [XL-1:0] p_data;
    logic [IW-1:0] p_idx;
    logic          p_last;
    int            j;
    got_data.delete(); got_idx.delete(); got_last.delete(); got_j.delete();
    done_cnt = 0; done_j = -1; first_valid_j = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    j = 1;
    while (j < 3000 && !(done_cnt > 0 && j > done_j + 3)) begin
      if (j == 1) chk("busy_after_start", 64'(busy), 64'd1);
      if (prev_stall) begin
        chk("stall_valid", 64'(dump_valid), 64'd1);
        chk("stall_data",  dump_data, p_data);
        chk("stall_index", 64'(dump_index), 64'(p_idx));
        chk("stall_last",  64'(dump_last), 64'(p_last));
      end
      if (dump_valid && first_valid_j < 0) first_valid_j = j;
      if (done) begin
        done_cnt++;
        done_j = j;
        chk("done_with_valid", 64'(dump_valid), 64'd0);
      end
      if (mode == 2 && !wrote && dump_valid && dump_index == IW'(8)) begin
        regs[3]  = 64'hDEAD;
        regs[12] = 64'hBEEF;
        wrote    = 1;
      end
      if (mode == 3 && dump_valid && dump_index == IW'(11)) begin
        reset = 1'b0;
        #1 chk_outputs_zero("async_reset");
        @(negedge clk);
        chk_outputs_zero("held_reset");
        reset = 1'b1;
        return;
      end
      dump_ready = ($urandom_range(0, 99) < pct);
      if (dump_valid && dump_ready) begin
        got_data.push_back(dump_data);
        got_idx.push_back(dump_index);
        got_last.push_back(dump_last);
        got_j.push_back(j);
      end
      prev_stall = dump_valid && !dump_ready;
      p_data = dump_data; p_idx = dump_index; p_last = dump_last;
      start = (mode == 1) && busy && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      j++;
    end
    start = 1'b0;
    chk("done_count", 64'(done_cnt), 64'd1);
  endtask

  // Reference: every register once in index order, then the XOR beat when enabled.
  task automatic compare_beats(input string tag);
    logic [XL-1:0] x = '0;
    int n;
    chk({tag, "_beats"}, 64'(got_data.size()), 64'(NBEATS));
    n = (got_data.size() < NBEATS) ? got_data.size() : NBEATS;
    for (int i = 0; i < n; i++) begin
      if (i < NR) begin
        chk($sformatf("%s_idx%0d", tag, i),  64'(got_idx[i]), 64'(i));
        chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_v[i]);
        chk($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(NBEATS == NR && i == NR - 1));
        x ^= exp_v[i];
      end else begin
        chk({tag, "_csum_data"},  got_data[i], x);
        chk({tag, "_csum_index"}, 64'(got_idx[i]), 64'd0);
        chk({tag, "_csum_last"},  64'(got_last[i]), 64'd1);
      end
    end
  endtask

  task automatic preload_a();
    for (int i = 0; i < NR; i++) begin
      regs[i]  = 64'h1111_1111_0000_0000 + 64'(i);
      exp_v[i] = 64'h1111_1111_0000_0000 + 64'(i);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; dump_ready = 1'b0;
    preload_a();
    #1 chk_outputs_zero("reset_state");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Full-rate dump with cycle-accurate timing.
    run_dump(100, 0);
    compare_beats("full");
    chk("first_valid_cycle", 64'(first_valid_j), 64'd2);
    if (got_j.size() >= NR) begin
      chk("final_hs_cycle", 64'(got_j[NR - 1]), 64'd48);
      chk("done_cycle", 64'(done_j), 64'(got_j[got_j.size() - 1] + 1));
    end

    // Random backpressure.
    run_dump(30, 0);
    compare_beats("stall");

    // Reset mid-dump, then a clean restart from index 0.
    run_dump(100, 3);
    run_dump(100, 0);
    compare_beats("after_reset");

    // Start pulses while busy are ignored.
    run_dump(70, 1);
    compare_beats("busy_start");

    // Write during pair 4: reg 3 already captured, reg 12 not yet.
    run_dump(100, 2);
    exp_v[12] = 64'hBEEF;
    compare_beats("mid_write");

    // Regs hold their own index; checksum of 0..31 is zero.
    for (int i = 0; i < NR; i++) begin
      regs[i]  = 64'(i);
      exp_v[i] = 64'(i);
    end
    run_dump(60, 0);
    compare_beats("index_data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
